fma_nrm_rnd: RTL

- Final stage of the double-precision FMA datapath. Sits directly downstream of the 82-bit carry-resolved adder output (the `add` stage).
- Takes the signed-magnitude sum plus an unbiased-exponent estimate and special-case tags.
- Normalises via leading-zero count and shift, rounds per IEEE-754 rounding mode, and packs the 64-bit result and 5-bit exception flags.
- Three-stage pipeline with valid/ready handshake and global stall.

---
 rtl/fma_nrm_rnd.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fma_nrm_rnd.sv
// fma_nrm_rnd: FMA normalise/round/pack stage, three pipeline stages (LZC, shift, round)
// with a global stall that freezes every stage while the result is held.
module fma_nrm_rnd #(
    parameter int FW = 82,
    parameter int EW = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [FW-1:0] in_frac,
    input  logic          in_sticky,
    input  logic          in_nan,
    input  logic          in_inv,
    input  logic          in_inf,
    input  logic [2:0]    in_rm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   rslt,
    output logic [4:0]    flag
);
    localparam int LW = $clog2(FW + 1);

    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    logic [LW-1:0] lz;
    logic [EW:0]   e0;
    always_comb begin
        lz = LW'(FW);
        for (int i = 0; i < FW; i++)
            if (in_frac[i]) lz = LW'(FW - 1 - i);
    end
    assign e0 = {in_exp[EW-1], in_exp} + (EW+1)'(1) - (EW+1)'(lz);

    logic          v1, s1_sign, s1_sticky, s1_nan, s1_inv, s1_inf;
    logic [2:0]    s1_rm;
    logic [FW-1:0] s1_frac;
    logic [LW-1:0] s1_lz;
    logic [EW:0]   s1_e;
    logic [EW-1:0] s1_exp;

    // Subnormal results align to the fixed 2^-1074 grid: shift by the raw exponent instead of L.
    logic          nrm, rgt, lost;
    logic [EW-1:0] neg;
    logic [LW-1:0] rsh, lsh;
    logic [FW-1:0] sh;
    assign nrm  = !s1_e[EW] && s1_e != '0 && s1_frac != '0;
    assign rgt  = !nrm && s1_exp[EW-1];
    assign neg  = EW'(0) - s1_exp;
    assign rsh  = (neg > EW'(FW)) ? LW'(FW) : LW'(neg);
    assign lsh  = nrm ? s1_lz : LW'(s1_exp);
    assign sh   = rgt ? (s1_frac >> rsh) : (s1_frac << lsh);
    assign lost = rgt && |(s1_frac & ~({FW{1'b1}} << rsh));

    logic        v2, s2_sign, s2_g, s2_s, s2_tiny, s2_zero, s2_nan, s2_inv, s2_inf;
    logic [2:0]  s2_rm;
    logic [52:0] s2_m;
    logic [EW:0] s2_ef;

    // Exponent field is stored minus one so the hidden bit of a normal mantissa restores it,
    // and a subnormal whose rounding carries into the hidden bit lands on exponent 1.
    logic          rne, inc, nx, of, ovf_inf;
    logic [EW+52:0] sum;
    logic [EW:0]   fe;
    logic [63:0]   r3;
    logic [4:0]    f3;
    assign rne     = s2_rm == 3'd0 || s2_rm > 3'd4;
    assign nx      = s2_g || s2_s;
    assign inc     = s2_rm == 3'd1 ? 1'b0 :
                     s2_rm == 3'd2 ? s2_sign && nx :
                     s2_rm == 3'd3 ? !s2_sign && nx :
                     s2_rm == 3'd4 ? s2_g :
                     s2_g && (s2_s || s2_m[0]);
    assign sum     = {s2_ef, 52'b0} + (EW+53)'(s2_m) + (EW+53)'(inc);
    assign fe      = sum[EW+52:52];
    assign of      = !fe[EW] && fe >= (EW+1)'(2047);
    assign ovf_inf = rne || s2_rm == 3'd4 || (s2_rm == 3'd2 && s2_sign) || (s2_rm == 3'd3 && !s2_sign);
    assign r3 = s2_nan  ? 64'h7FF8_0000_0000_0000 :
                s2_inf  ? {s2_sign, 11'h7FF, 52'b0} :
                s2_zero ? {s2_sign, 63'b0} :
                of      ? (ovf_inf ? {s2_sign, 11'h7FF, 52'b0} : {s2_sign, 63'h7FEF_FFFF_FFFF_FFFF}) :
                {s2_sign, sum[62:0]};
    assign f3 = (s2_nan || s2_inf || s2_zero) ? {s2_inv, 4'b0} :
                {s2_inv, 1'b0, of, s2_tiny && nx && !of, nx || of};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            rslt      <= '0;
            flag      <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            rslt      <= r3;
            flag      <= f3;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sign   <= in_sign;
            s1_sticky <= in_sticky;
            s1_nan    <= in_nan;
            s1_inv    <= in_inv;
            s1_inf    <= in_inf;
            s1_rm     <= in_rm;
            s1_frac   <= in_frac;
            s1_lz     <= lz;
            s1_e      <= e0;
            s1_exp    <= in_exp;
            s2_sign   <= s1_sign;
            s2_nan    <= s1_nan;
            s2_inv    <= s1_inv;
            s2_inf    <= s1_inf;
            s2_rm     <= s1_rm;
            s2_m      <= sh[FW-1 -: 53];
            s2_g      <= sh[FW-54];
            s2_s      <= |sh[FW-55:0] || s1_sticky || lost;
            s2_ef     <= nrm ? s1_e - (EW+1)'(1) : '0;
            s2_tiny   <= !nrm;
            s2_zero   <= s1_frac == '0 && !s1_sticky;
        end
    end
endmodule
